// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions: FSM state encoding plus HTRANS, HRESP and
// HSIZE code points.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge. Word transfers only; other sizes get a
// two-cycle ERROR response without touching APB.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PADDR_W = 16
) (
    input  logic               hclk_i,
    input  logic               hreset_i,
    input  logic               hsel_i,
    input  logic [WIDTH-1:0]   haddr_i,
    input  logic [1:0]         htrans_i,
    input  logic               hwrite_i,
    input  logic [2:0]         hsize_i,
    input  logic [WIDTH-1:0]   hwdata_i,
    input  logic               hreadyin_i,
    output logic [WIDTH-1:0]   hrdata_o,
    output logic               hreadyout_o,
    output logic [1:0]         hresp_o,
    output logic [PADDR_W-1:0] paddr_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [WIDTH-1:0]   pwdata_o,
    input  logic [WIDTH-1:0]   prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    state_t r_state, w_next;

    logic [WIDTH-1:0]   r_hrdata;
    logic               r_hready;
    logic [1:0]         r_hresp;
    logic [PADDR_W-1:0] r_paddr;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [WIDTH-1:0]   r_pwdata;

    logic w_valid;
    logic w_unused;

    // Only the low PADDR_W address bits reach APB.
    assign w_unused = &{1'b0, haddr_i[WIDTH-1:PADDR_W]};

    assign w_valid = hsel_i & hreadyin_i & r_hready &
                     ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_next = ST_IDLE;
                if (w_valid)
                    w_next = (hsize_i == HSIZE_WORD) ? ST_LATCH : ST_ERR1;
            end
            ST_LATCH:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i)
                    w_next = pslverr_i ? ST_ERR1 : ST_IDLE;
            end
            ST_ERR1:   w_next = ST_ERR2;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies decoded from the next state.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            r_state   <= ST_IDLE;
            r_hready  <= 1'b1;
            r_hresp   <= HRESP_OKAY;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_hrdata  <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            r_state   <= w_next;
            r_hready  <= (w_next == ST_IDLE) || (w_next == ST_ERR2);
            r_hresp   <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            r_psel    <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
            r_penable <= (w_next == ST_ACCESS);
            if (w_next == ST_LATCH) begin
                r_paddr  <= haddr_i[PADDR_W-1:0];
                r_pwrite <= hwrite_i;
            end
            if ((r_state == ST_LATCH) && r_pwrite)
                r_pwdata <= hwdata_i;
            if ((r_state == ST_ACCESS) && pready_i && !pslverr_i && !r_pwrite)
                r_hrdata <= prdata_i;
        end
    end

    assign hrdata_o    = r_hrdata;
    assign hreadyout_o = r_hready;
    assign hresp_o     = r_hresp;
    assign paddr_o     = r_paddr;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed plus random transfers for ahb2apb_bridge, checked against a
// transaction-level model of wait states, response and APB accesses.
module tb_ahb2apb_bridge;

    logic        hclk_i, hreset_i, hsel_i, hwrite_i, hreadyin_i;
    logic [31:0] haddr_i, hwdata_i, hrdata_o, pwdata_o, prdata_i;
    logic [1:0]  htrans_i, hresp_o;
    logic [2:0]  hsize_i;
    logic        hreadyout_o, psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic [15:0] paddr_o;

    ahb2apb_bridge #(.WIDTH(32), .PADDR_W(16)) dut (
        .hclk_i(hclk_i), .hreset_i(hreset_i), .hsel_i(hsel_i), .haddr_i(haddr_i),
        .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
        .hreadyin_i(hreadyin_i), .hrdata_o(hrdata_o), .hreadyout_o(hreadyout_o),
        .hresp_o(hresp_o), .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    initial hclk_i = 1'b0;
    always #5 hclk_i = ~hclk_i;

    typedef struct packed {
        logic [15:0] a;
        logic        w;
        logic [31:0] d;
    } rec_t;

    rec_t        acc_q[$];
    int          setup_cnt = 0;
    int          acc_cnt;
    int          cfg_waits = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [31:0] exp_rdata = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // APB slave: holds pready low for cfg_waits ACCESS cycles.
    always_comb begin
        pready_i  = (acc_cnt >= cfg_waits);
        pslverr_i = cfg_err & pready_i;
        prdata_i  = cfg_rdata;
    end

    always @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) acc_cnt <= 0;
        else if (psel_o && penable_o) acc_cnt <= pready_i ? 0 : acc_cnt + 1;
    end

    always @(posedge hclk_i) begin
        if (!hreset_i) begin
            if (psel_o && penable_o && pready_i)
                acc_q.push_back(rec_t'{a: paddr_o, w: pwrite_o, d: pwdata_o});
            if (psel_o && !penable_o) setup_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input int wt, input logic er,
                        input logic [31:0] rd);
        int         low, q0, s0, exp_low;
        logic [1:0] last_resp;
        logic       ok_size, exp_err;
        rec_t       r;
        cfg_waits = wt; cfg_err = er; cfg_rdata = rd;
        q0 = acc_q.size(); s0 = setup_cnt;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = a; hwrite_i = w; hsize_i = sz;
        @(posedge hclk_i); #1;
        hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = wd; haddr_i = $urandom;
        hwrite_i = $urandom_range(0, 1);
        low = 0; last_resp = 2'b00;
        while (hreadyout_o !== 1'b1 && low < 200) begin
            low++; last_resp = hresp_o;
            @(posedge hclk_i); #1;
        end
        ok_size = (sz == 3'b010);
        exp_err = !ok_size || er;
        exp_low = !ok_size ? 1 : (3 + wt + (er ? 1 : 0));
        chk("wait_states", low, exp_low);
        chk("hresp_ready", hresp_o, exp_err ? 2'b01 : 2'b00);
        if (exp_err) chk("hresp_wait", last_resp, 2'b01);
        chk("apb_accesses", acc_q.size() - q0, ok_size ? 1 : 0);
        chk("apb_setups", setup_cnt - s0, ok_size ? 1 : 0);
        if (ok_size && acc_q.size() > q0) begin
            r = acc_q[$];
            chk("paddr", r.a, a[15:0]);
            chk("pwrite", r.w, w);
            if (w) chk("pwdata", r.d, wd);
        end
        if (ok_size && !er && !w) exp_rdata = rd;
        chk("hrdata", hrdata_o, exp_rdata);
    endtask

    initial begin
        int n;
        hreset_i = 1'b1; hsel_i = 0; haddr_i = 0; htrans_i = 0; hwrite_i = 0;
        hsize_i = 3'b010; hwdata_i = 0; hreadyin_i = 1;
        #12;
        chk("rst_hready", hreadyout_o, 1); chk("rst_hresp", hresp_o, 0);
        chk("rst_hrdata", hrdata_o, 0);    chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);  chk("rst_pwrite", pwrite_o, 0);
        chk("rst_paddr", paddr_o, 0);      chk("rst_pwdata", pwdata_o, 0);
        @(posedge hclk_i); #1 hreset_i = 1'b0;

        // First transfer right after reset release.
        xfer(32'h0000_1234, 1, 3'b010, 32'hDEADBEEF, 0, 0, 32'h0);
        xfer(32'h0000_0040, 0, 3'b010, 32'h0, 3, 0, 32'hA5A5_5A5A);
        chk("read_hrdata", hrdata_o, 32'hA5A5_5A5A);
        xfer(32'h0000_0080, 0, 3'b010, 32'h0, 0, 1, 32'h1111_2222);
        xfer(32'h0000_0100, 1, 3'b000, 32'h5555_AAAA, 0, 0, 32'h0);
        // Back-to-back: second address lands in the first's completion cycle.
        xfer(32'h0000_2000, 1, 3'b010, 32'h0BAD_F00D, 0, 0, 32'h0);
        xfer(32'h0000_2004, 1, 3'b010, 32'hCAFE_0001, 1, 0, 32'h0);

        // Non-transfers are ignored.
        n = acc_q.size();
        for (int i = 0; i < 4; i++) begin
            hsel_i     = (i != 1);
            htrans_i   = (i == 0) ? 2'b01 : (i == 3) ? 2'b11 : 2'b10;
            hreadyin_i = (i != 2) && (i != 3);
            if (i == 3) hsel_i = 1'b0;
            @(posedge hclk_i); #1;
            chk("ign_hready", hreadyout_o, 1); chk("ign_hresp", hresp_o, 0);
            chk("ign_psel", psel_o, 0);
        end
        hsel_i = 0; htrans_i = 0; hreadyin_i = 1;
        @(posedge hclk_i); #1;
        chk("ign_accesses", acc_q.size() - n, 0);

        for (int i = 0; i < 24; i++)
            xfer($urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010,
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom);

        // Reset during ACCESS.
        cfg_waits = 10; cfg_err = 0;
        hsel_i = 1; htrans_i = 2'b10; haddr_i = 32'h0000_0300; hwrite_i = 0; hsize_i = 3'b010;
        @(posedge hclk_i); #1;
        hsel_i = 0; htrans_i = 0;
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin n++; @(posedge hclk_i); #1; end
        chk("reach_access", psel_o & penable_o, 1);
        @(posedge hclk_i); #2 hreset_i = 1'b1;
        #1;
        chk("mid_rst_psel", psel_o, 0);     chk("mid_rst_penable", penable_o, 0);
        chk("mid_rst_hready", hreadyout_o, 1); chk("mid_rst_hresp", hresp_o, 0);
        chk("mid_rst_paddr", paddr_o, 0);
        exp_rdata = '0;
        @(posedge hclk_i); #1 hreset_i = 1'b0;
        xfer(32'h0000_0444, 0, 3'b010, 32'h0, 1, 0, 32'h7777_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
